// File: rtl/dm_ctrl_pipe_if.sv
// Request/response bus for dm_ctrl_pipe: valid/ready request channel plus a
// registered, back-pressurable response channel.
interface dm_ctrl_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
);
  logic              req_valid;
  logic              req_ready;
  logic              req_load;
  logic              req_store;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_load, req_store, req_size, req_signed, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_load, req_store, req_size, req_signed, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dm_ctrl_pipe.sv
// MEM-stage data memory: byte-addressed loads/stores with extension, one-entry response stage.
// Optional macro DM_MISALIGN_TRAP_EN turns misaligned half/word/double accesses into errors.
module dm_ctrl_pipe #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 12,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  dm_ctrl_pipe_if.slave  bus
);
  localparam int LANES = DATA_W / 8;
  localparam int LB    = $clog2(LANES);
  localparam int DEPTH = 1 << (ADDR_W - LB);

  logic [DATA_W-1:0] r_mem [DEPTH] = '{default: {DATA_W{INIT_ZERO ? 1'b0 : 1'bx}}};

  logic              r_vld, r_err;
  logic [DATA_W-1:0] r_rdata;

  logic              w_ready, w_fire, w_op_bad, w_size_bad, w_mis, w_err, w_wr, w_sbit;
  logic [LB-1:0]     w_amask, w_off;
  logic [LANES-1:0]  w_bmask, w_be;
  logic [ADDR_W-LB-1:0] w_idx;
  logic [DATA_W-1:0] w_wsh, w_rsh, w_ld;
  int                w_msb;

  always_comb begin
    w_amask = '0;
    w_bmask = '0;
    w_msb   = 7;
    case (bus.req_size)
      2'd0: begin w_amask = '0;      w_bmask = LANES'(1);     w_msb = 7;  end
      2'd1: begin w_amask = LB'(1);  w_bmask = LANES'(3);     w_msb = 15; end
      2'd2: begin w_amask = LB'(3);  w_bmask = LANES'(4'hF);  w_msb = 31; end
      2'd3: begin w_amask = LB'(7);  w_bmask = '1;            w_msb = 63; end
    endcase
    if (w_msb > DATA_W - 1) w_msb = DATA_W - 1;
  end

  // Low address bits below the access size are dropped, so an unaligned
  // access in non-trapping mode lands on the enclosing aligned datum.
  assign w_off      = bus.req_addr[LB-1:0] & ~w_amask;
  assign w_idx      = bus.req_addr[ADDR_W-1:LB];
  assign w_op_bad   = (bus.req_load == bus.req_store);
  assign w_size_bad = (bus.req_size == 2'b11) && (DATA_W < 64);
`ifdef DM_MISALIGN_TRAP_EN
  assign w_mis      = |(bus.req_addr[LB-1:0] & w_amask);
`else
  assign w_mis      = 1'b0;
`endif
  assign w_err      = w_op_bad | w_size_bad | w_mis;

  assign w_ready    = !r_vld || bus.resp_ready;
  assign w_fire     = bus.req_valid && w_ready;
  assign w_wr       = w_fire && bus.req_store && !w_err;

  assign w_be       = w_bmask << w_off;
  assign w_wsh      = bus.req_wdata << {w_off, 3'b000};
  assign w_rsh      = r_mem[w_idx] >> {w_off, 3'b000};

  always_comb begin
    w_ld   = '0;
    w_sbit = bus.req_signed & w_rsh[w_msb];
    for (int b = 0; b < DATA_W; b++)
      w_ld[b] = (b <= w_msb) ? w_rsh[b] : w_sbit;
  end

  always_ff @(posedge clk) begin
    if (w_wr)
      for (int i = 0; i < LANES; i++)
        if (w_be[i]) r_mem[w_idx][i*8 +: 8] <= w_wsh[i*8 +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else if (w_fire) begin
      r_vld   <= 1'b1;
      r_err   <= w_err;
      r_rdata <= (bus.req_load && !w_err) ? w_ld : '0;
    end else if (bus.resp_ready) begin
      r_vld   <= 1'b0;
    end
  end

  assign bus.req_ready  = w_ready;
  assign bus.resp_valid = r_vld;
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;
endmodule

// File: tb/tb_dm_ctrl_pipe.sv
// Directed bench for dm_ctrl_pipe: 32- and 64-bit instances, vector table plus
// back-pressure and mid-response reset sequences.
module tb_dm_ctrl_pipe;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dm_ctrl_pipe_if #(.DATA_W(32), .ADDR_W(12)) b32 ();
  dm_ctrl_pipe_if #(.DATA_W(64), .ADDR_W(12)) b64 ();

  dm_ctrl_pipe #(.DATA_W(32), .ADDR_W(12), .INIT_ZERO(1'b1)) u32 (
    .clk(clk), .rst_n(rst_n), .bus(b32.slave));
  dm_ctrl_pipe #(.DATA_W(64), .ADDR_W(12), .INIT_ZERO(1'b1)) u64 (
    .clk(clk), .rst_n(rst_n), .bus(b64.slave));

  typedef struct {
    string       name;
    bit          dw64;
    bit          ld;
    bit          st;
    logic [1:0]  sz;
    bit          sg;
    logic [11:0] addr;
    logic [63:0] wd;
    logic [63:0] exp;
    bit          err;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic void add(input string nm, input bit dw64, input bit ld, input bit st,
                              input logic [1:0] sz, input bit sg, input logic [11:0] addr,
                              input logic [63:0] wd, input logic [63:0] exp, input bit err);
    vec_t v;
    v.name = nm; v.dw64 = dw64; v.ld = ld; v.st = st; v.sz = sz; v.sg = sg;
    v.addr = addr; v.wd = wd; v.exp = exp; v.err = err;
    tbl.push_back(v);
  endfunction

  task automatic drive32(input bit vld, input bit ld, input bit st, input logic [1:0] sz,
                         input bit sg, input logic [11:0] addr, input logic [31:0] wd);
    b32.req_valid = vld; b32.req_load = ld; b32.req_store = st; b32.req_size = sz;
    b32.req_signed = sg; b32.req_addr = addr; b32.req_wdata = wd;
  endtask

  task automatic drive64(input bit vld, input bit ld, input bit st, input logic [1:0] sz,
                         input bit sg, input logic [11:0] addr, input logic [63:0] wd);
    b64.req_valid = vld; b64.req_load = ld; b64.req_store = st; b64.req_size = sz;
    b64.req_signed = sg; b64.req_addr = addr; b64.req_wdata = wd;
  endtask

  // One request per cycle with resp_ready held high: accepted on the next edge,
  // response visible right after that same edge.
  task automatic apply(input vec_t v);
    @(negedge clk);
    if (v.dw64) begin
      drive32(0, 0, 0, 0, 0, 0, 0);
      drive64(1, v.ld, v.st, v.sz, v.sg, v.addr, v.wd);
    end else begin
      drive64(0, 0, 0, 0, 0, 0, 0);
      drive32(1, v.ld, v.st, v.sz, v.sg, v.addr, v.wd[31:0]);
    end
    #1;
    chk({v.name, " req_ready"}, v.dw64 ? 64'(b64.req_ready) : 64'(b32.req_ready), 64'd1);
    @(posedge clk); #1;
    if (v.dw64) begin
      chk({v.name, " valid"}, 64'(b64.resp_valid), 64'd1);
      chk({v.name, " rdata"}, b64.resp_rdata, v.exp);
      chk({v.name, " err"},   64'(b64.resp_err), 64'(v.err));
    end else begin
      chk({v.name, " valid"}, 64'(b32.resp_valid), 64'd1);
      chk({v.name, " rdata"}, 64'(b32.resp_rdata), v.exp);
      chk({v.name, " err"},   64'(b32.resp_err), 64'(v.err));
    end
  endtask

  initial begin
    //   name          64 ld st sz    sg addr     wdata                  expected              err
    add("sw010",       0, 0, 1, 2'd2, 0, 12'h010, 64'h8899AABB,          64'h0,                0);
    add("lw010",       0, 1, 0, 2'd2, 1, 12'h010, 64'h0,                 64'h8899AABB,         0);
    add("sb021",       0, 0, 1, 2'd0, 0, 12'h021, 64'hF0,                64'h0,                0);
    add("lb021",       0, 1, 0, 2'd0, 1, 12'h021, 64'h0,                 64'hFFFFFFF0,         0);
    add("lbu021",      0, 1, 0, 2'd0, 0, 12'h021, 64'h0,                 64'h000000F0,         0);
    add("lw020",       0, 1, 0, 2'd2, 0, 12'h020, 64'h0,                 64'h0000F000,         0);
    add("sh032",       0, 0, 1, 2'd1, 0, 12'h032, 64'h8001,              64'h0,                0);
    add("lh032",       0, 1, 0, 2'd1, 1, 12'h032, 64'h0,                 64'hFFFF8001,         0);
    add("lhu032",      0, 1, 0, 2'd1, 0, 12'h032, 64'h0,                 64'h00008001,         0);
    add("lw030",       0, 1, 0, 2'd2, 0, 12'h030, 64'h0,                 64'h80010000,         0);
    add("sw004",       0, 0, 1, 2'd2, 0, 12'h004, 64'h11223344,          64'h0,                0);
`ifdef DM_MISALIGN_TRAP_EN
    add("lw006",       0, 1, 0, 2'd2, 0, 12'h006, 64'h0,                 64'h0,                1);
`else
    add("lw006",       0, 1, 0, 2'd2, 0, 12'h006, 64'h0,                 64'h11223344,         0);
`endif
    add("ldst004",     0, 1, 1, 2'd2, 0, 12'h004, 64'hDEADBEEF,          64'h0,                1);
    add("lw004",       0, 1, 0, 2'd2, 0, 12'h004, 64'h0,                 64'h11223344,         0);
    add("noop",        0, 0, 0, 2'd2, 0, 12'h004, 64'h0,                 64'h0,                1);
    add("ld32",        0, 1, 0, 2'd3, 0, 12'h008, 64'h0,                 64'h0,                1);
    add("swtop",       0, 0, 1, 2'd2, 0, 12'hFFC, 64'hCAFEF00D,          64'h0,                0);
    add("lwtop",       0, 1, 0, 2'd2, 0, 12'hFFC, 64'h0,                 64'hCAFEF00D,         0);
    add("lbtop",       0, 1, 0, 2'd0, 1, 12'hFFF, 64'h0,                 64'hFFFFFFCA,         0);
    add("sd008",       1, 0, 1, 2'd3, 0, 12'h008, 64'h0123456789ABCDEF,  64'h0,                0);
    add("lw00c",       1, 1, 0, 2'd2, 1, 12'h00C, 64'h0,                 64'h0000000001234567, 0);
    add("lw008",       1, 1, 0, 2'd2, 1, 12'h008, 64'h0,                 64'hFFFFFFFF89ABCDEF, 0);
    add("ld008",       1, 1, 0, 2'd3, 0, 12'h008, 64'h0,                 64'h0123456789ABCDEF, 0);
    add("lhu00e",      1, 1, 0, 2'd1, 0, 12'h00E, 64'h0,                 64'h0000000000000123, 0);
    add("sb00f",       1, 0, 1, 2'd0, 0, 12'h00F, 64'h80,                64'h0,                0);
    add("ld008b",      1, 1, 0, 2'd3, 1, 12'h008, 64'h0,                 64'h8023456789ABCDEF, 0);

    rst_n = 1'b0;
    drive32(0, 0, 0, 0, 0, 0, 0);
    drive64(0, 0, 0, 0, 0, 0, 0);
    b32.resp_ready = 1'b1;
    b64.resp_ready = 1'b1;
    #1;
    chk("rst valid32", 64'(b32.resp_valid), 64'd0);
    chk("rst rdata32", 64'(b32.resp_rdata), 64'd0);
    chk("rst err32",   64'(b32.resp_err),   64'd0);
    chk("rst valid64", 64'(b64.resp_valid), 64'd0);
    chk("rst rdata64", b64.resp_rdata,      64'd0);
    chk("rst ready32", 64'(b32.req_ready),  64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);

    // Back-pressure: load response parked, a store waits behind it.
    @(negedge clk);
    drive64(0, 0, 0, 0, 0, 0, 0);
    b32.resp_ready = 1'b0;
    drive32(1, 1, 0, 2'd2, 0, 12'h010, 32'h0);
    @(posedge clk); #1;
    chk("bp first valid", 64'(b32.resp_valid), 64'd1);
    chk("bp first rdata", 64'(b32.resp_rdata), 64'h8899AABB);
    @(negedge clk);
    drive32(1, 0, 1, 2'd2, 0, 12'h010, 32'h55555555);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("bp hold ready", 64'(b32.req_ready),  64'd0);
      chk("bp hold valid", 64'(b32.resp_valid), 64'd1);
      chk("bp hold rdata", 64'(b32.resp_rdata), 64'h8899AABB);
      chk("bp hold err",   64'(b32.resp_err),   64'd0);
    end
    @(negedge clk);
    b32.resp_ready = 1'b1;
    drive32(1, 1, 0, 2'd2, 0, 12'h010, 32'h0);
    #1;
    chk("bp release ready", 64'(b32.req_ready), 64'd1);
    @(posedge clk); #1;
    chk("bp release valid", 64'(b32.resp_valid), 64'd1);
    chk("bp no write",      64'(b32.resp_rdata), 64'h8899AABB);
    @(negedge clk);
    drive32(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("idle clears valid", 64'(b32.resp_valid), 64'd0);

    // Reset while a 64-bit response is pending.
    @(negedge clk);
    b64.resp_ready = 1'b0;
    drive64(1, 1, 0, 2'd3, 0, 12'h008, 64'h0);
    @(posedge clk); #1;
    chk("pre-rst valid64", 64'(b64.resp_valid), 64'd1);
    drive64(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("async rst valid64", 64'(b64.resp_valid), 64'd0);
    chk("async rst rdata64", b64.resp_rdata,      64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    b64.resp_ready = 1'b1;
    begin
      vec_t v;
      v.name = "ld after rst"; v.dw64 = 1; v.ld = 1; v.st = 0; v.sz = 2'd3; v.sg = 0;
      v.addr = 12'h008; v.wd = 64'h0; v.exp = 64'h8023456789ABCDEF; v.err = 0;
      apply(v);
      v.name = "lw010 after rst"; v.dw64 = 0; v.sz = 2'd2; v.addr = 12'h010; v.exp = 64'h8899AABB;
      apply(v);
    end
    @(negedge clk);
    drive32(0, 0, 0, 0, 0, 0, 0);
    drive64(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
